charge_accum_ctrl: RTL and testbench
====================================

// Module: charge_accum_ctrl
// PURPOSE
//  Sequences read-modify-write accumulation of signed neuron charge held in the 16x256 dual-port charge RAM (dp_ram_16x256).
//  Accepts weighted input events, adds each weight to the stored charge and compares the result to a threshold.
//  On threshold crossing it zeroes the stored charge and emits a fire event.
//  Owns both RAM ports; also provides a full-array clear sweep that has priority over accumulation.
// PARAMETERS
//  ADDR_W    8   neuron address width (RAM depth = 2**ADDR_W)
//  CHARGE_W  16  stored charge width (signed, two's complement)
//  WEIGHT_W  8   input weight width (signed, sign-extended to CHARGE_W)
// PORTS
//  clk          in   1         single clock; all logic on posedge
//  reset        in   1         asynchronous, active-low (0 = in reset)
//  acc_valid    in   1         accumulate request valid
//  acc_ready    out  1         accumulate request accepted when valid&ready
//  acc_addr     in   ADDR_W    target neuron
//  acc_weight   in   WEIGHT_W  signed weight to add
//  threshold    in   CHARGE_W  signed fire threshold; sampled at stage 1, static in normal use
//  fire_valid   out  1         fire event valid
//  fire_ready   in   1         fire event consumed when valid&ready
//  fire_addr    out  ADDR_W    neuron that fired
//  clear_req    in   1         1-cycle pulse: zero entire RAM
//  clear_busy   out  1         clear sweep in progress
//  ram_rd_en/ram_rd_addr, ram_wr_en/ram_wr_addr/ram_wr_data   out   to RAM ports
//  ram_rd_data  in   CHARGE_W  RAM read data (valid 1 cycle after ram_rd_en)
// BEHAVIOUR
//  Reset: acc_ready=0, fire_valid=0, fire_addr=0, clear_busy=0, ram_rd_en=0, ram_wr_en=0, pipeline/forward regs invalid.
//   RAM contents are NOT reset; software issues clear_req after reset.
//  FSM: IDLE, ACC, CLEAR. After reset goes to IDLE. IDLE->ACC when not clearing. Any state->CLEAR on clear_req once the pipeline drains.
//   CLEAR->ACC after writing address 2**ADDR_W-1.
//  Stage 0 (accept): on acc_valid&acc_ready drive ram_rd_en=1 and ram_rd_addr=acc_addr; register addr/weight and set s1_valid.
//  Stage 1 (+1 cycle): old = forward hit ? fwd_data : ram_rd_data.
//   sum = sat(old + sext(weight)), saturating to [-2**(CHARGE_W-1), 2**(CHARGE_W-1)-1].
//   If sum >= threshold (signed): write 0 and raise fire_valid with fire_addr=addr. Otherwise write sum.
//   ram_wr_en pulses in this same cycle. Latency: accept to write = 1 cycle; accept to fire_valid = 2 cycles (registered).
//  Forwarding: store the last write (addr,data,valid). A stage-1 read whose addr matches the write from the previous cycle uses fwd_data.
//   Back-to-back same-address events must accumulate exactly; no bubbles.
//  Throughput: one event per cycle. acc_ready = (state==ACC) & ~clear_pending & (~fire_valid | fire_ready).
//  Fire handshake: fire_valid holds with stable fire_addr until fire_ready. While it is held, acc_ready=0, so at most one more fire can be produced.
//   A 1-entry skid register absorbs a fire from an event already in stage 1. Fires are never dropped or reordered.
//  Clear: clear_req sets clear_pending and drops acc_ready. Once stage 1 is empty and no fire is stalled, enter CLEAR.
//   Write 0 to addresses 0..2**ADDR_W-1, one per cycle, with clear_busy=1. Invalidate the forward register.
//   Pending fire events remain deliverable during the clear.
//  clear_req during CLEAR: ignored. clear_req with acc_valid in the same cycle: the clear wins and the event is not accepted.
//  Reset mid-operation: asynchronous abort. In-flight event and pending fire are lost, RAM is left partially updated.
//  Read and write on the same RAM address in one cycle: the RAM returns the old data; forwarding covers this case.
// STRUCTURE
//  ucaspian_pkg: typedefs charge_t (signed CHARGE_W), addr_t, weight_t; localparams CHARGE_MAX, CHARGE_MIN; enum acc_state_t {IDLE,ACC,CLEAR}.
//  Sub-module charge_sat_add: combinational saturating add of charge_t + sign-extended weight_t.
//  The RAM itself is instantiated by the parent, not inside this block.
// TESTING
//  1. Reset, clear_req, then 256 writes of 0 -> clear_busy high for 256 cycles; reading any address afterwards returns 0.
//  2. threshold=100; events addr 5 with weights +40,+40,+40 on consecutive cycles -> forwarding sums 40,80, then 120 crosses threshold. RAM[5]=0, one fire at addr 5.
//  3. threshold=32767; 300 events of +127 to addr 9 -> charge saturates at 32767 and fires on reaching 32767. Then -128 x300 -> saturates at -32768 with no fire.
//  4. fire_ready=0 while events to addrs 1,2 (threshold=1, weight=+5) stream -> fires 1 then 2 delivered in order after fire_ready=1. acc_ready low while stalled.
//  5. clear_req during a back-to-back event stream -> the event in flight completes, no new accepts, sweep runs, then accumulation resumes from 0.
//  6. reset asserted mid-clear at address 100 -> all outputs return to reset values immediately; a new clear_req completes normally.

Source files
------------

// File: rtl/charge_accum_ctrl_pkg.sv
// charge_accum_ctrl_pkg: shared widths, types, limits and FSM states for the
// neuron charge accumulator and its saturating adder.
package charge_accum_ctrl_pkg;

    localparam int ADDR_W   = 8;
    localparam int CHARGE_W = 16;
    localparam int WEIGHT_W = 8;

    typedef logic signed [CHARGE_W-1:0] charge_t;
    typedef logic        [ADDR_W-1:0]   addr_t;
    typedef logic signed [WEIGHT_W-1:0] weight_t;

    localparam charge_t CHARGE_MAX = {1'b0, {(CHARGE_W-1){1'b1}}};
    localparam charge_t CHARGE_MIN = {1'b1, {(CHARGE_W-1){1'b0}}};

    // Highest RAM address; the clear sweep ends after writing it.
    localparam addr_t LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        CLEAR = 2'd2
    } acc_state_t;

    // Sign-extend a weight to the charge width.
    function automatic charge_t sext_weight(input weight_t w);
        return {{(CHARGE_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    endfunction

endpackage

// File: rtl/charge_accum_ctrl_sat_add.sv
// charge_sat_add: combinational charge + sign-extended weight, clamped to the
// representable signed charge range instead of wrapping.
module charge_sat_add
    import charge_accum_ctrl_pkg::*;
(
    input  logic [CHARGE_W-1:0] charge_i,
    input  logic [WEIGHT_W-1:0] weight_i,
    output logic [CHARGE_W-1:0] sum_o
);

    charge_t           weight_ext;
    logic [CHARGE_W:0] wide_sum;

    // One guard bit exposes overflow: if it disagrees with the charge MSB the
    // true sum left the range and the guard bit tells which rail to clamp to.
    always_comb begin
        weight_ext = sext_weight(weight_t'(weight_i));
        wide_sum   = {charge_i[CHARGE_W-1], charge_i}
                   + {weight_ext[CHARGE_W-1], weight_ext};
        if (wide_sum[CHARGE_W] != wide_sum[CHARGE_W-1]) begin
            sum_o = wide_sum[CHARGE_W] ? CHARGE_MIN : CHARGE_MAX;
        end else begin
            sum_o = wide_sum[CHARGE_W-1:0];
        end
    end

endmodule

// File: rtl/charge_accum_ctrl.sv
// charge_accum_ctrl: read-modify-write accumulation of signed neuron charge in
// an external dual-port RAM. Stage 0 issues the read, stage 1 adds, compares
// against the threshold and writes back (zero on fire). A one-deep write
// forward covers the RAM's read-old-on-collision behaviour, and a full-array
// clear sweep takes priority over accumulation once the pipeline drains.
module charge_accum_ctrl
    import charge_accum_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                acc_valid_i,
    output logic                acc_ready_o,
    input  logic [ADDR_W-1:0]   acc_addr_i,
    input  logic [WEIGHT_W-1:0] acc_weight_i,
    input  logic [CHARGE_W-1:0] threshold_i,

    output logic                fire_valid_o,
    input  logic                fire_ready_i,
    output logic [ADDR_W-1:0]   fire_addr_o,

    input  logic                clear_req_i,
    output logic                clear_busy_o,

    output logic                ram_rd_en_o,
    output logic [ADDR_W-1:0]   ram_rd_addr_o,
    output logic                ram_wr_en_o,
    output logic [ADDR_W-1:0]   ram_wr_addr_o,
    output logic [CHARGE_W-1:0] ram_wr_data_o,
    input  logic [CHARGE_W-1:0] ram_rd_data_i
);

    // Controller state
    acc_state_t state_q;
    logic       clear_pending_q;
    logic       clear_busy_q;
    addr_t      clear_addr_q;

    // Stage 1 registers (event whose read data arrives this cycle)
    logic       s1_valid_q;
    addr_t      s1_addr_q;
    weight_t    s1_weight_q;

    // Last stage-1 write, for same-address back-to-back events
    logic       fwd_valid_q;
    addr_t      fwd_addr_q;
    charge_t    fwd_data_q;

    // Fire output register plus one-entry skid
    logic       fire_valid_q, fire_valid_d;
    addr_t      fire_addr_q,  fire_addr_d;
    logic       skid_valid_q, skid_valid_d;
    addr_t      skid_addr_q,  skid_addr_d;

    // Datapath wires
    logic       accept;
    logic       fwd_hit;
    charge_t    s1_old;
    charge_t    s1_sum;
    charge_t    s1_thresh;
    logic       s1_fire;
    charge_t    s1_wr_data;
    logic       fire_slot_free;

    // Accept only in ACC with no clear requested or pending, and only when
    // the fire output is free (or being emptied this cycle), so that at most
    // one more fire can land behind a stalled one.
    assign fire_slot_free = ~fire_valid_q | fire_ready_i;
    assign acc_ready_o    = (state_q == ACC) & ~clear_pending_q & ~clear_req_i
                          & fire_slot_free;
    assign accept         = acc_valid_i & acc_ready_o;

    // Stage 0 drives the read port straight from the request.
    assign ram_rd_en_o   = accept;
    assign ram_rd_addr_o = acc_addr_i;

    // The RAM returns the old value when it was written last cycle at the
    // same address, so take the forwarded value instead.
    assign fwd_hit   = fwd_valid_q & (fwd_addr_q == s1_addr_q);
    assign s1_old    = fwd_hit ? fwd_data_q : charge_t'(ram_rd_data_i);
    assign s1_thresh = charge_t'(threshold_i);

    charge_sat_add u_sat_add (
        .charge_i (s1_old),
        .weight_i (s1_weight_q),
        .sum_o    (s1_sum)
    );

    assign s1_fire    = s1_valid_q & (s1_sum >= s1_thresh);
    assign s1_wr_data = s1_fire ? '0 : s1_sum;

    // The write port is shared by the sweep and stage 1; they never overlap
    // because the sweep only starts once stage 1 is empty.
    assign ram_wr_en_o   = s1_valid_q | (state_q == CLEAR);
    assign ram_wr_addr_o = (state_q == CLEAR) ? clear_addr_q : s1_addr_q;
    assign ram_wr_data_o = (state_q == CLEAR) ? '0 : s1_wr_data;

    assign fire_valid_o = fire_valid_q;
    assign fire_addr_o  = fire_addr_q;
    assign clear_busy_o = clear_busy_q;

    // Controller FSM: latch clear requests, wait for stage 1 and the skid to
    // empty, then sweep every address once before returning to ACC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            clear_pending_q <= 1'b0;
            clear_busy_q    <= 1'b0;
            clear_addr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_req_i) begin
                        clear_pending_q <= 1'b1;
                    end
                    state_q <= ACC;
                end
                ACC: begin
                    if (clear_req_i) begin
                        clear_pending_q <= 1'b1;
                    end
                    if (clear_pending_q && !s1_valid_q && !skid_valid_q) begin
                        state_q         <= CLEAR;
                        clear_pending_q <= 1'b0;
                        clear_busy_q    <= 1'b1;
                        clear_addr_q    <= '0;
                    end
                end
                CLEAR: begin
                    if (clear_addr_q == LAST_ADDR) begin
                        state_q      <= ACC;
                        clear_busy_q <= 1'b0;
                    end else begin
                        clear_addr_q <= clear_addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage 0 -> stage 1 hand-off of the accepted event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_weight_q <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_addr_q   <= addr_t'(acc_addr_i);
                s1_weight_q <= weight_t'(acc_weight_i);
            end
        end
    end

    // Remember the stage-1 write for exactly one cycle; the sweep zeroes the
    // array so any remembered value would be stale afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= (state_q == CLEAR) ? 1'b0 : s1_valid_q;
            if (s1_valid_q) begin
                fwd_addr_q <= s1_addr_q;
                fwd_data_q <= s1_wr_data;
            end
        end
    end

    // Next fire output: the skid entry is older than a fresh stage-1 fire, so
    // it moves to the output first; a fire arriving while the output is held
    // parks in the skid.
    always_comb begin
        fire_valid_d = fire_valid_q;
        fire_addr_d  = fire_addr_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        if (fire_slot_free) begin
            if (skid_valid_q) begin
                fire_valid_d = 1'b1;
                fire_addr_d  = skid_addr_q;
                skid_valid_d = s1_fire;
                skid_addr_d  = s1_addr_q;
            end else if (s1_fire) begin
                fire_valid_d = 1'b1;
                fire_addr_d  = s1_addr_q;
                skid_valid_d = 1'b0;
            end else begin
                fire_valid_d = 1'b0;
            end
        end else if (s1_fire) begin
            skid_valid_d = 1'b1;
            skid_addr_d  = s1_addr_q;
        end
    end

    // Registered fire output and skid entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fire_valid_q <= 1'b0;
            fire_addr_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
        end else begin
            fire_valid_q <= fire_valid_d;
            fire_addr_q  <= fire_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
        end
    end

endmodule

// File: tb/tb_charge_accum_ctrl.sv
// tb_charge_accum_ctrl: drives the accumulator with directed and random
// events, owns a behavioural charge RAM, and checks every write and fire
// against a plain-arithmetic charge model kept in the bench.
module tb_charge_accum_ctrl;

    logic        clk = 1'b0;
    logic        rstN;
    logic        accValid;
    logic        accReady;
    logic [7:0]  accAddr;
    logic [7:0]  accWeight;
    logic [15:0] threshold;
    logic        fireValid;
    logic        fireReady;
    logic [7:0]  fireAddr;
    logic        clearReq;
    logic        clearBusy;
    logic        ramRdEn;
    logic [7:0]  ramRdAddr;
    logic        ramWrEn;
    logic [7:0]  ramWrAddr;
    logic [15:0] ramWrData;
    logic [15:0] ramRdData;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    int model [256];
    int expWrAddr [$];
    int expWrData [$];
    int expFire [$];
    int wrLog [$];
    int fireLog [$];
    int clearNext = 0;
    int clearRun = 0;
    int lastClearRun = 0;
    int prevHeld = 0;
    int prevAddr = 0;

    always #5 clk = ~clk;

    charge_accum_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .acc_valid_i   (accValid),
        .acc_ready_o   (accReady),
        .acc_addr_i    (accAddr),
        .acc_weight_i  (accWeight),
        .threshold_i   (threshold),
        .fire_valid_o  (fireValid),
        .fire_ready_i  (fireReady),
        .fire_addr_o   (fireAddr),
        .clear_req_i   (clearReq),
        .clear_busy_o  (clearBusy),
        .ram_rd_en_o   (ramRdEn),
        .ram_rd_addr_o (ramRdAddr),
        .ram_wr_en_o   (ramWrEn),
        .ram_wr_addr_o (ramWrAddr),
        .ram_wr_data_o (ramWrData),
        .ram_rd_data_i (ramRdData)
    );

    // Dual-port RAM stand-in: synchronous read that returns the old word on a
    // same-address write, contents start as garbage.
    initial begin
        ramRdData = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        forever begin
            @(posedge clk);
            if (ramRdEn) ramRdData <= mem[ramRdAddr];
            if (ramWrEn) mem[ramWrAddr] <= ramWrData;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int satAdd(input int c, input int w);
        int s;
        s = c + w;
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Per-cycle scoreboard: writes, clear sweep, fires and accepts are all
    // judged against the bench's own charge model.
    always @(negedge clk) begin
        int a;
        int s;
        int th;
        if (rstN) begin
            if (ramWrEn) begin
                if (clearBusy) begin
                    checkOutput("clearNoEventWrite", expWrAddr.size(), 0);
                    checkOutput("clearAddr", int'(ramWrAddr), clearNext);
                    checkOutput("clearData", int'(ramWrData), 0);
                    model[ramWrAddr] = 0;
                    clearNext++;
                    clearRun++;
                end else if (expWrAddr.size() == 0) begin
                    checkOutput("unexpectedWrite", int'(ramWrAddr), -1);
                end else begin
                    checkOutput("wrAddr", int'(ramWrAddr), expWrAddr.pop_front());
                    checkOutput("wrData", int'($signed(ramWrData)), expWrData.pop_front());
                    wrLog.push_back(int'($signed(ramWrData)));
                end
            end
            if (!clearBusy && clearRun != 0) begin
                lastClearRun = clearRun;
                clearRun = 0;
                clearNext = 0;
            end
            if (clearReq || clearBusy || (fireValid && !fireReady)) begin
                checkOutput("readyBlocked", int'(accReady), 0);
            end
            if (prevHeld != 0) begin
                checkOutput("fireHeldValid", int'(fireValid), 1);
                checkOutput("fireHeldAddr", int'(fireAddr), prevAddr);
            end
            prevHeld = int'(fireValid && !fireReady);
            prevAddr = int'(fireAddr);
            if (fireValid && fireReady) begin
                if (expFire.size() == 0) begin
                    checkOutput("unexpectedFire", int'(fireAddr), -1);
                end else begin
                    checkOutput("fireAddr", int'(fireAddr), expFire.pop_front());
                end
                fireLog.push_back(int'(fireAddr));
            end
            if (accValid && accReady) begin
                a  = int'(accAddr);
                th = int'($signed(threshold));
                s  = satAdd(model[a], int'($signed(accWeight)));
                if (s >= th) begin
                    model[a] = 0;
                    expWrAddr.push_back(a);
                    expWrData.push_back(0);
                    expFire.push_back(a);
                end else begin
                    model[a] = s;
                    expWrAddr.push_back(a);
                    expWrData.push_back(s);
                end
            end
        end
    end

    task automatic applyStimulus(input int addr, input int weight);
        int n;
        int accepted;
        accepted = 0;
        n = 0;
        accValid  = 1'b1;
        accAddr   = 8'(addr);
        accWeight = 8'(weight);
        while (accepted == 0 && n < 2000) begin
            @(negedge clk);
            if (accReady) accepted = 1;
            n++;
        end
        @(posedge clk);
        #1;
        accValid = 1'b0;
        checkOutput("accepted", accepted, 1);
    endtask

    task automatic pulseClear();
        clearReq = 1'b1;
        @(posedge clk);
        #1;
        clearReq = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitClearDone(input string name);
        int n;
        n = 0;
        while (!clearBusy && n < 50) begin @(negedge clk); n++; end
        while (clearBusy && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        checkOutput(name, lastClearRun, 256);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "AccReady"}, int'(accReady), 0);
        checkOutput({tag, "FireValid"}, int'(fireValid), 0);
        checkOutput({tag, "FireAddr"}, int'(fireAddr), 0);
        checkOutput({tag, "ClearBusy"}, int'(clearBusy), 0);
        checkOutput({tag, "RdEn"}, int'(ramRdEn), 0);
        checkOutput({tag, "WrEn"}, int'(ramWrEn), 0);
    endtask

    initial begin
        int fc;
        int n;
        int w;
        rstN = 1'b0;
        accValid = 1'b0;
        accAddr = '0;
        accWeight = '0;
        threshold = 16'd100;
        fireReady = 1'b1;
        clearReq = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 0;
        #1;
        checkResetOutputs("reset");
        waitCycles(3);
        rstN = 1'b1;
        waitCycles(2);

        // Test 1: full clear after reset.
        lastClearRun = 0;
        pulseClear();
        waitClearDone("clearRun1");
        for (int i = 0; i < 256; i += 17) checkOutput("memZero", int'(mem[i]), 0);

        // Test 2: forwarding on back-to-back same-address events.
        threshold = 16'd100;
        wrLog.delete();
        fc = fireLog.size();
        applyStimulus(5, 40);
        applyStimulus(5, 40);
        applyStimulus(5, 40);
        waitCycles(4);
        checkOutput("fwdWrites", wrLog.size(), 3);
        if (wrLog.size() == 3) begin
            checkOutput("fwdSum1", wrLog[0], 40);
            checkOutput("fwdSum2", wrLog[1], 80);
            checkOutput("fwdSum3", wrLog[2], 0);
        end
        checkOutput("fwdMem5", int'($signed(mem[5])), 0);
        checkOutput("fwdFires", fireLog.size() - fc, 1);

        // Test 3: positive and negative saturation.
        threshold = 16'd32767;
        fc = fireLog.size();
        for (int i = 0; i < 300; i++) applyStimulus(9, 127);
        waitCycles(4);
        checkOutput("satPosFires", fireLog.size() - fc, 1);
        checkOutput("satPosMem9", int'($signed(mem[9])), 5207);
        for (int i = 0; i < 300; i++) applyStimulus(9, -128);
        waitCycles(4);
        checkOutput("satNegMem9", int'($signed(mem[9])), -32768);
        checkOutput("satNegFires", fireLog.size() - fc, 1);

        // Test 4: stalled fire output with a second fire in the skid.
        threshold = 16'd1;
        fireReady = 1'b0;
        fc = fireLog.size();
        applyStimulus(1, 5);
        applyStimulus(2, 5);
        waitCycles(3);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("stallReady", int'(accReady), 0);
        end
        checkOutput("stallFireValid", int'(fireValid), 1);
        checkOutput("stallFireAddr", int'(fireAddr), 1);
        @(posedge clk);
        #1;
        fireReady = 1'b1;
        waitCycles(4);
        checkOutput("stallFires", fireLog.size() - fc, 2);
        if (fireLog.size() - fc == 2) begin
            checkOutput("stallOrder1", fireLog[fc], 1);
            checkOutput("stallOrder2", fireLog[fc + 1], 2);
        end

        // Test 5: clear request in the middle of a back-to-back stream.
        threshold = 16'd30000;
        lastClearRun = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) applyStimulus($urandom_range(0, 7), $urandom_range(0, 20));
            end
            begin
                waitCycles(10);
                pulseClear();
            end
        join
        waitCycles(4);
        checkOutput("midClearRun", lastClearRun, 256);
        applyStimulus(200, 7);
        waitCycles(3);
        checkOutput("resumeMem200", int'($signed(mem[200])), 7);

        // Test 6: reset in the middle of a clear sweep, then a fresh clear.
        pulseClear();
        n = 0;
        while (!(clearBusy && ramWrEn && ramWrAddr == 8'd100) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachedAddr100", int'(ramWrAddr), 100);
        #2;
        rstN = 1'b0;
        #1;
        checkResetOutputs("midReset");
        expWrAddr.delete();
        expWrData.delete();
        expFire.delete();
        clearRun = 0;
        clearNext = 0;
        prevHeld = 0;
        waitCycles(2);
        rstN = 1'b1;
        waitCycles(2);
        lastClearRun = 0;
        pulseClear();
        waitClearDone("clearRunAfterReset");

        // Random phase: random events, fire back-pressure and rare clears.
        threshold = 16'd150;
        for (int i = 0; i < 2500; i++) begin
            w = $urandom_range(0, 90) - 30;
            accValid  = ($urandom_range(0, 3) != 0);
            accAddr   = 8'($urandom_range(0, 15));
            accWeight = 8'(w);
            fireReady = ($urandom_range(0, 3) != 0);
            clearReq  = (!clearReq && $urandom_range(0, 299) == 0);
            @(posedge clk);
            #1;
        end
        accValid = 1'b0;
        clearReq = 1'b0;
        fireReady = 1'b1;
        n = 0;
        while ((clearBusy || fireValid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        waitCycles(5);

        checkOutput("pendingWrites", expWrAddr.size(), 0);
        checkOutput("pendingFires", expFire.size(), 0);
        for (int i = 0; i < 256; i++) checkOutput("finalCharge", int'($signed(mem[i])), model[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
